// File: rtl/move_sequencer_pkg.sv
// Shared types and defaults for the move sequencer and its forward-speed ramp.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package move_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        MOVE  = 2'd2,
        DECEL = 2'd3
    } state_t;

    localparam logic [9:0]  FRWRD_INC_DEF = 10'd2;
    localparam logic [9:0]  MAX_FRWRD_DEF = 10'h2A0;
    localparam logic [11:0] HDG_TOL_DEF   = 12'd44;

    // Each square is bounded by two tape lines seen by the centre IR sensor.
    localparam logic [4:0]  XING_PER_SQR  = 5'd2;

    // Magnitude of a 12-bit two's-complement value. 12'h800 maps to itself,
    // which reads as 2048 unsigned and therefore never passes a tolerance test.
    function automatic logic [11:0] abs12(input logic [11:0] v);
        return v[11] ? (~v + 12'd1) : v;
    endfunction

endpackage

// File: rtl/move_sequencer_frwrd_ramp.sv
// Saturating up/down forward-speed counter: +UP_STEP capped at CEIL, -DN_STEP floored at 0.
// Latency: value updates on the edge that samples inc/dec/clr; clr has priority, then inc, then dec.
// Backpressure: none; every enable is honoured in the cycle it is presented.
// Ports: clk, rst_n (async, active-low), clr, inc, dec in; value[9:0] out.
module frwrd_ramp
    import move_seq_pkg::*;
#(
    parameter logic [9:0] UP_STEP = FRWRD_INC_DEF,
    parameter logic [9:0] DN_STEP = {FRWRD_INC_DEF[7:0], 2'b00},
    parameter logic [9:0] CEIL    = MAX_FRWRD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [9:0] value
);

    // One extra bit so a step near the ceiling cannot wrap before the compare.
    logic [10:0] up_sum;

    assign up_sum = {1'b0, value} + {1'b0, UP_STEP};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 10'd0;
        end else if (clr) begin
            value <= 10'd0;
        end else if (inc) begin
            value <= (up_sum > {1'b0, CEIL}) ? CEIL : up_sum[9:0];
        end else if (dec) begin
            value <= (value < DN_STEP) ? 10'd0 : (value - DN_STEP);
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Move sequencer: turn to heading, ramp up, count line crossings, ramp down, report done.
// Latency: command accepted -> TURN next cycle; heading_rdy -> error/err_vld next cycle.
// Backpressure: mv_rdy is high only in IDLE; mv_vld at any other time is dropped, not queued.
// Ports: mv_vld/mv_hdg/mv_sqrs/mv_rdy command handshake; heading/heading_rdy gyro in;
//        cntrIR line sensor in; error/err_vld/moving/frwrd to the PID; mv_done completion pulse.
module move_sequencer
    import move_seq_pkg::*;
#(
    parameter logic [9:0]  FRWRD_INC = FRWRD_INC_DEF,
    parameter logic [9:0]  MAX_FRWRD = MAX_FRWRD_DEF,
    parameter logic [11:0] HDG_TOL   = HDG_TOL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mv_vld,
    input  logic [11:0] mv_hdg,
    input  logic [3:0]  mv_sqrs,
    output logic        mv_rdy,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic [11:0] error,
    output logic        err_vld,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic        mv_done
);

    localparam logic [9:0] FRWRD_DEC = {FRWRD_INC[7:0], 2'b00};

    state_t      state;
    logic [11:0] desired_hdg;
    logic [4:0]  sqr_target;
    logic [4:0]  xing_cnt;
    logic        cntr_ir_q;

    logic [11:0] hdg_diff;
    logic [11:0] hdg_mag;
    logic        in_tol;
    logic        xing_edge;
    logic        ramp_inc;
    logic        ramp_dec;

    // Plain 12-bit subtraction: heading is circular, so wrap-around is the
    // correct shortest-path error.
    assign hdg_diff  = heading - desired_hdg;
    assign hdg_mag   = abs12(hdg_diff);
    assign in_tol    = (hdg_mag < HDG_TOL);
    assign xing_edge = cntrIR & ~cntr_ir_q;

    assign mv_rdy    = (state == IDLE);
    assign moving    = (state != IDLE);
    assign ramp_inc  = (state == MOVE)  && heading_rdy;
    assign ramp_dec  = (state == DECEL) && heading_rdy;

    frwrd_ramp #(
        .UP_STEP (FRWRD_INC),
        .DN_STEP (FRWRD_DEC),
        .CEIL    (MAX_FRWRD)
    ) u_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .inc   (ramp_inc),
        .dec   (ramp_dec),
        .value (frwrd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            desired_hdg <= 12'd0;
            sqr_target  <= 5'd0;
            xing_cnt    <= 5'd0;
            cntr_ir_q   <= 1'b0;
            error       <= 12'd0;
            err_vld     <= 1'b0;
            mv_done     <= 1'b0;
        end else begin
            cntr_ir_q <= cntrIR;
            err_vld   <= heading_rdy && (state != IDLE);
            mv_done   <= (state == DECEL) && (frwrd == 10'd0);
            if (heading_rdy && (state != IDLE)) begin
                error <= hdg_diff;
            end

            case (state)
                IDLE: begin
                    if (mv_vld) begin
                        desired_hdg <= mv_hdg;
                        sqr_target  <= {1'b0, mv_sqrs} * XING_PER_SQR;
                        xing_cnt    <= 5'd0;
                        state       <= TURN;
                    end
                end
                TURN: begin
                    if (heading_rdy && in_tol) begin
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (xing_edge && (xing_cnt != 5'd31)) begin
                        xing_cnt <= xing_cnt + 5'd1;
                    end
                    // Compared against the registered count every cycle, so the
                    // exit lands one edge after the satisfying crossing and a
                    // zero-square move leaves on its first MOVE cycle.
                    if (xing_cnt == sqr_target) begin
                        state <= DECEL;
                    end
                end
                DECEL: begin
                    if (frwrd == 10'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mv_vld = 1'b0;
    logic [11:0] mv_hdg = 12'd0;
    logic [3:0]  mv_sqrs = 4'd0;
    logic        mv_rdy;
    logic [11:0] heading = 12'd0;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic [11:0] error;
    logic        err_vld;
    logic        moving;
    logic [9:0]  frwrd;
    logic        mv_done;

    int checks = 0;
    int failures = 0;

    move_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mv_vld      (mv_vld),
        .mv_hdg      (mv_hdg),
        .mv_sqrs     (mv_sqrs),
        .mv_rdy      (mv_rdy),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .cntrIR      (cntrIR),
        .error       (error),
        .err_vld     (err_vld),
        .moving      (moving),
        .frwrd       (frwrd),
        .mv_done     (mv_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (specification arithmetic) ----------
    function automatic logic [11:0] exp_err(input logic [11:0] h, input logic [11:0] d);
        int e;
        e = (int'(h) - int'(d)) & 4095;
        return e[11:0];
    endfunction

    function automatic bit within_tol(input logic [11:0] h, input logic [11:0] d);
        int e;
        e = (int'(h) - int'(d)) & 4095;
        if (e >= 2048) e = e - 4096;
        return (e > -44) && (e < 44);
    endfunction

    function automatic int ramp_up(input int f, input int n);
        return (f + 2 * n > 672) ? 672 : f + 2 * n;
    endfunction

    function automatic int ramp_down(input int f, input int n);
        return (f - 8 * n < 0) ? 0 : f - 8 * n;
    endfunction

    // ---------------- stimulus helpers ------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hr_pulses(input int n, input logic [11:0] h);
        heading     = h;
        heading_rdy = 1'b1;
        step(n);
        heading_rdy = 1'b0;
    endtask

    task automatic issue(input logic [11:0] hdg, input logic [3:0] sq);
        mv_hdg  = hdg;
        mv_sqrs = sq;
        mv_vld  = 1'b1;
        step(1);
        mv_vld  = 1'b0;
    endtask

    // ---------------- scenarios -------------------------------------------
    task automatic test_reset;
        #1;
        checks++; if (mv_rdy !== 1'b1) begin failures++; $display("FAIL rst_mv_rdy got=%b exp=1", mv_rdy); end
        checks++; if ({moving, err_vld, mv_done} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {moving, err_vld, mv_done}); end
        checks++; if (frwrd !== 10'd0 || error !== 12'd0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", frwrd, error); end
        step(2);
        rst_n = 1'b1;
        step(1);
        hr_pulses(1, 12'h123);
        checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL idle_err_vld got=%b exp=0", err_vld); end
    endtask

    task automatic test_turn;
        issue(12'h3FF, 4'd1);
        checks++; if (moving !== 1'b1 || mv_rdy !== 1'b0) begin failures++; $display("FAIL accept got=%b%b exp=10", moving, mv_rdy); end
        hr_pulses(1, 12'h000);
        checks++; if (error !== 12'hC01 || err_vld !== 1'b1) begin failures++; $display("FAIL turn_err got=%h/%b exp=c01/1", error, err_vld); end
        step(1);
        checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL err_vld_width got=%b exp=0", err_vld); end
        hr_pulses(1, 12'h3F0);
        checks++; if (error !== 12'hFF1 || frwrd !== 10'd0) begin failures++; $display("FAIL turn_done got=%h/%h exp=ff1/0", error, frwrd); end
    endtask

    task automatic test_ramp;
        hr_pulses(5, 12'h3F0);
        checks++; if (frwrd !== 10'd10) begin failures++; $display("FAIL ramp5 got=%0d exp=10", frwrd); end
        hr_pulses(400, 12'h3F0);
        checks++; if (frwrd !== 10'h2A0) begin failures++; $display("FAIL ramp_sat got=%h exp=2a0", frwrd); end
    endtask

    task automatic test_busy;
        mv_hdg = 12'h100;
        mv_vld = 1'b1;
        step(3);
        mv_vld = 1'b0;
        checks++; if (mv_rdy !== 1'b0 || moving !== 1'b1) begin failures++; $display("FAIL busy_flags got=%b%b exp=01", mv_rdy, moving); end
        hr_pulses(1, 12'h3F0);
        checks++; if (error !== 12'hFF1) begin failures++; $display("FAIL busy_hdg got=%h exp=ff1", error); end
    endtask

    task automatic test_crossings;
        cntrIR = 1'b1;
        step(3);
        hr_pulses(1, 12'h3F0);
        checks++; if (frwrd !== 10'h2A0) begin failures++; $display("FAIL xing1_still_move got=%h exp=2a0", frwrd); end
        cntrIR = 1'b0;
        step(2);
        cntrIR = 1'b1;
        step(2);
        hr_pulses(1, 12'h3F0);
        checks++; if (frwrd !== 10'h298) begin failures++; $display("FAIL xing2_decel got=%h exp=298", frwrd); end
        hr_pulses(82, 12'h3F0);
        checks++; if (frwrd !== 10'd8) begin failures++; $display("FAIL decel_mid got=%0d exp=8", frwrd); end
        hr_pulses(1, 12'h3F0);
        checks++; if (frwrd !== 10'd0 || moving !== 1'b1 || mv_done !== 1'b0) begin failures++; $display("FAIL decel_zero got=%h/%b/%b exp=0/1/0", frwrd, moving, mv_done); end
        step(1);
        checks++; if (mv_done !== 1'b1 || mv_rdy !== 1'b1 || moving !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b%b%b exp=110", mv_done, mv_rdy, moving); end
        step(1);
        checks++; if (mv_done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", mv_done); end
        cntrIR = 1'b0;
        step(1);
    endtask

    task automatic test_ignored_edges;
        issue(12'h000, 4'd1);
        for (int i = 0; i < 4; i++) begin
            cntrIR = ~cntrIR;
            step(1);
        end
        hr_pulses(1, 12'h005);
        hr_pulses(3, 12'h005);
        checks++; if (frwrd !== 10'd6) begin failures++; $display("FAIL turn_edges_ignored got=%0d exp=6", frwrd); end
        cntrIR = 1'b1; step(1); cntrIR = 1'b0; step(2);
        hr_pulses(1, 12'h005);
        checks++; if (frwrd !== 10'd8) begin failures++; $display("FAIL one_edge_move got=%0d exp=8", frwrd); end
        cntrIR = 1'b1; step(1); cntrIR = 1'b0; step(2);
        hr_pulses(1, 12'h005);
        step(1);
        checks++; if (mv_done !== 1'b1 || frwrd !== 10'd0) begin failures++; $display("FAIL ign_done got=%b/%0d exp=1/0", mv_done, frwrd); end
        step(1);
    endtask

    task automatic test_zero_length;
        mv_hdg = 12'h000; mv_sqrs = 4'd0; mv_vld = 1'b1;
        step(1);
        mv_vld = 1'b0;
        heading = 12'h005; heading_rdy = 1'b1;
        step(1);
        heading_rdy = 1'b0;
        checks++; if (moving !== 1'b1 || mv_done !== 1'b0) begin failures++; $display("FAIL zero_move got=%b%b exp=10", moving, mv_done); end
        step(1);
        checks++; if (moving !== 1'b1 || mv_done !== 1'b0 || frwrd !== 10'd0) begin failures++; $display("FAIL zero_decel got=%b%b/%0d exp=10/0", moving, mv_done, frwrd); end
        step(1);
        checks++; if (mv_done !== 1'b1 || moving !== 1'b0 || frwrd !== 10'd0) begin failures++; $display("FAIL zero_done got=%b%b/%0d exp=10/0", mv_done, moving, frwrd); end
        step(1);
    endtask

    task automatic test_wrap_and_reset;
        issue(12'h7F0, 4'd1);
        hr_pulses(1, 12'h810);
        checks++; if (error !== 12'h020 || frwrd !== 10'd0) begin failures++; $display("FAIL wrap_err got=%h/%0d exp=020/0", error, frwrd); end
        hr_pulses(40, 12'h810);
        checks++; if (frwrd !== 10'h050) begin failures++; $display("FAIL pre_reset got=%h exp=050", frwrd); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (frwrd !== 10'd0 || moving !== 1'b0 || mv_rdy !== 1'b1 || err_vld !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b%b%b exp=0/010", frwrd, moving, mv_rdy, err_vld); end
        step(1);
        rst_n = 1'b1;
        step(1);
        checks++; if (mv_rdy !== 1'b1 || moving !== 1'b0) begin failures++; $display("FAIL post_reset got=%b%b exp=10", mv_rdy, moving); end
    endtask

    task automatic test_random_moves;
        for (int m = 0; m < 8; m++) begin
            logic [11:0] hdg, h;
            logic [3:0]  sq;
            int          off, k, f, n, tmp;
            bit          done;
            hdg = 12'($urandom);
            sq  = 4'($urandom_range(1, 3));
            checks++; if (mv_rdy !== 1'b1) begin failures++; $display("FAIL rnd_rdy m=%0d got=%b exp=1", m, mv_rdy); end
            issue(hdg, sq);
            done = 1'b0;
            for (int t = 0; t < 20 && !done; t++) begin
                if (t == 19 || $urandom_range(0, 2) == 0) begin
                    off = int'($urandom_range(0, 86)) - 43;
                end else begin
                    off = int'($urandom_range(44, 2048));
                    if ($urandom_range(0, 1) == 1) off = -off;
                end
                tmp = (int'(hdg) + off) & 4095;
                h   = tmp[11:0];
                hr_pulses(1, h);
                checks++; if (error !== exp_err(h, hdg) || err_vld !== 1'b1) begin failures++; $display("FAIL rnd_turn_err m=%0d got=%h exp=%h", m, error, exp_err(h, hdg)); end
                done = within_tol(h, hdg);
                step($urandom_range(0, 2));
            end
            checks++; if (frwrd !== 10'd0) begin failures++; $display("FAIL rnd_turn_frwrd m=%0d got=%0d exp=0", m, frwrd); end
            k = $urandom_range(1, 400);
            h = 12'($urandom);
            mv_hdg = 12'($urandom);
            mv_vld = 1'($urandom_range(0, 1));
            hr_pulses(k, h);
            mv_vld = 1'b0;
            f = ramp_up(0, k);
            checks++; if (frwrd !== 10'(f) || error !== exp_err(h, hdg)) begin failures++; $display("FAIL rnd_ramp m=%0d got=%0d/%h exp=%0d/%h", m, frwrd, error, f, exp_err(h, hdg)); end
            for (int i = 0; i < 2 * int'(sq); i++) begin
                cntrIR = 1'b1; step($urandom_range(1, 3));
                cntrIR = 1'b0; step($urandom_range(1, 3));
            end
            n = (f + 7) / 8;
            hr_pulses(n, h);
            checks++; if (frwrd !== 10'(ramp_down(f, n)) || moving !== 1'b1) begin failures++; $display("FAIL rnd_decel m=%0d got=%0d/%b exp=%0d/1", m, frwrd, moving, ramp_down(f, n)); end
            step(1);
            checks++; if (mv_done !== 1'b1 || moving !== 1'b0) begin failures++; $display("FAIL rnd_done m=%0d got=%b%b exp=10", m, mv_done, moving); end
            step($urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset;
        test_turn;
        test_ramp;
        test_busy;
        test_crossings;
        test_ignored_edges;
        test_zero_length;
        test_wrap_and_reset;
        test_random_moves;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Command-level sequencer that drives the PID steering datapath. It accepts a move command (desired heading and square count) and turns in place until the heading error is within tolerance. It then ramps forward speed up, counts line crossings, and ramps speed down to a stop. It generates the `error`, `err_vld`, `moving` and `frwrd` inputs consumed by the PID block, and reports completion upstream.

## Interface
- `FRWRD_INC`, default 10'd2: `frwrd` increment per `heading_rdy` during ramp-up; ramp-down step is 4×`FRWRD_INC`.
- `MAX_FRWRD`, default 10'h2A0: saturation ceiling for `frwrd`.
- `HDG_TOL`, default 12'd44: turn-complete threshold on |error|, strictly less-than.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `mv_vld`, in, 1: move command valid.
- `mv_hdg`, in, 12: desired heading, signed; sampled when accepted.
- `mv_sqrs`, in, 4: squares to travel, unsigned; sampled when accepted.
- `mv_rdy`, out, 1: high only in IDLE.
- `heading`, in, 12: signed gyro heading.
- `heading_rdy`, in, 1: one-cycle strobe; `heading` is valid this cycle.
- `cntrIR`, in, 1: line-crossing sensor level, already synchronized.
- `error`, out, 12: signed `heading − desired_hdg`, registered.
- `err_vld`, out, 1: one-cycle strobe; `error` is fresh.
- `moving`, out, 1: PID enable; its deassertion clears the PID integrator.
- `frwrd`, out, 10: forward speed to the PID.
- `mv_done`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, TURN, MOVE, DECEL.
- IDLE:
  - `mv_rdy=1`, `moving=0`, `frwrd=0`.
  - On `mv_vld`, latch `desired_hdg←mv_hdg` and `sqr_target←{mv_sqrs,1'b0}` (2 crossings per square).
  - Clear the crossing counter; go to TURN.
- TURN:
  - `moving=1`, `frwrd` held at 0.
  - On a `heading_rdy` cycle where |`heading−desired_hdg`| < `HDG_TOL`, go to MOVE.
- MOVE:
  - On each `heading_rdy`, `frwrd←min(frwrd+FRWRD_INC, MAX_FRWRD)`.
  - Count rising edges of `cntrIR` (registered previous value).
  - When count == `sqr_target`, go to DECEL. The check is evaluated every cycle, so `sqr_target=0` leaves MOVE on the first cycle.
- DECEL:
  - On each `heading_rdy`, `frwrd←max(frwrd−4·FRWRD_INC, 0)`, saturating at 0 with no underflow wrap.
  - When `frwrd==0`, go to IDLE and pulse `mv_done` for one cycle.
- Arithmetic:
  - Error is a 12-bit two's-complement subtraction; wrap-around is intended, since heading is circular.
  - Magnitude compare uses the absolute value. The most-negative value 12'h800 counts as out of tolerance.
- `cntrIR` edges outside MOVE are ignored. The crossing counter is 5 bits and saturates at 31.
- `mv_vld` outside IDLE is ignored; there is no queuing.
- `desired_hdg` stays constant for the whole move.

## Timing
- Reset values:
  - All outputs 0 except `mv_rdy=1`.
  - State IDLE; `desired_hdg`, counter and edge register all 0.
- Command acceptance: `mv_vld` accepted at edge T; TURN and `moving=1` from T+1.
- Error latency:
  - `heading_rdy` at cycle C gives `error` updated and `err_vld=1` at C+1, whenever the state is not IDLE.
  - `err_vld` is never asserted in IDLE.
- `frwrd` updates on the same edge that samples `heading_rdy`.
- State transitions:
  - TURN→MOVE on the edge that sampled the qualifying `heading_rdy`.
  - Entry to DECEL occurs the edge after the crossing that satisfies the count.
  - DECEL with `frwrd==0` → IDLE on the next edge. `mv_done` and `mv_rdy` rise together and `moving` falls in that same cycle.
- Reset mid-move: asynchronous return to IDLE; `frwrd` and `moving` go to 0 immediately.

## Structure
- Shared package `move_seq_pkg` holds:
  - the `state_t` enum (IDLE, TURN, MOVE, DECEL);
  - default constants for `FRWRD_INC`, `MAX_FRWRD` and `HDG_TOL`;
  - the crossings-per-square constant (2).
- One sub-module, `frwrd_ramp`: saturating up/down counter with `inc`/`dec` enables and a `clr` input, parameterized by step and ceiling.
- Error computation, tolerance compare and edge detect stay in the top level.

## Test plan
- Reset:
  - Assert `rst_n=0` mid-MOVE with `frwrd=0x50`.
  - Required: `frwrd=0`, `moving=0`, `mv_rdy=1`, `err_vld=0` without waiting for a clock edge.
- Turn:
  - Command `mv_hdg=0x3FF`, `heading=0x000`, pulse `heading_rdy`.
  - Required: `error=0xC01`, `err_vld` one cycle, state stays TURN.
  - Then `heading=0x3F0` with `heading_rdy`: error 15 < 44 → MOVE, `frwrd` still 0.
- Ramp-up:
  - In MOVE with `FRWRD_INC=2`, apply 5 `heading_rdy` pulses.
  - Required: `frwrd=10`.
  - After 400 pulses: `frwrd` holds at `0x2A0`.
- Crossings:
  - `mv_sqrs=1`; `cntrIR` toggles 0→1→0→1.
  - Required: DECEL after the 2nd rising edge.
  - From `0x2A0`, 84 `heading_rdy` pulses bring `frwrd` to 0, then a one-cycle `mv_done` with `moving` falling.
- Busy and zero-length move:
  - `mv_vld` during MOVE: ignored, `desired_hdg` unchanged.
  - `mv_sqrs=0`: TURN → MOVE → DECEL on consecutive cycles, then IDLE with `mv_done` while `frwrd` remains 0.
- Wrap-around:
  - `mv_hdg=0x7F0`, `heading=0x810`.
  - Required: `error=0x020` (32 < 44) → TURN completes.
